// File: rtl/boxhead_pkg.sv
// Shared types and helpers for the boxhead per-frame gameplay blocks.
package boxhead_pkg;

  localparam int HP_W   = 8;
  localparam int POS_W  = 9;
  localparam int DIFF_W = POS_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WINDUP  = 3'd1,
    STRIKE  = 3'd2,
    RECOVER = 3'd3,
    DEAD    = 3'd4
  } atk_state_t;

  // Magnitude of a - b, taken as a 10-bit signed difference of two unsigned positions.
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
    logic [DIFF_W-1:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DIFF_W-1] ? (~d + 10'd1) : d;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Synchronizes the vsync-rate frame clock into the Clk domain and emits a
// one-cycle tick on each rising edge. Shared by all per-frame blocks.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Two-flop synchronizer, edge history and registered rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync1_r <= frame_clk;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      tick    <= sync2_r & ~prev_r;
    end
  end

endmodule

// File: rtl/enemy_attack_ctrl.sv
// Enemy contact detection, windup/strike/recover FSM and player HP bookkeeping.
// Optional HP regeneration while idle is enabled with `define ENEMY_REGEN_EN.
module enemy_attack_ctrl
  import boxhead_pkg::*;
#(
  parameter int NUM_ENEMY      = 4,
  parameter int RANGE          = 12,
  parameter int WINDUP_FRAMES  = 3,
  parameter int RECOVER_FRAMES = 8,
  parameter int DAMAGE         = 10,
  parameter int MAX_HP         = 100,
  parameter int REGEN_FRAMES   = 60
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             frame_clk,
  input  logic [POS_W-1:0]                 Player_X,
  input  logic [POS_W-1:0]                 Player_Y,
  input  logic [NUM_ENEMY-1:0][POS_W-1:0]  Enemy_X,
  input  logic [NUM_ENEMY-1:0][POS_W-1:0]  Enemy_Y,
  input  logic [NUM_ENEMY-1:0]             Enemy_Alive,
  output logic                             Enemy_Attack_Ready,
  output logic                             Hit_Pulse,
  output logic [HP_W-1:0]                  Player_HP,
  output logic                             Player_Dead
);

  localparam logic [DIFF_W-1:0] RANGE_L   = DIFF_W'(RANGE);
  localparam logic [7:0]        WINDUP_L  = 8'(WINDUP_FRAMES);
  localparam logic [7:0]        RECOVER_L = 8'(RECOVER_FRAMES);
  localparam logic [HP_W-1:0]   DAMAGE_L  = HP_W'(DAMAGE);
  localparam logic [HP_W-1:0]   MAX_HP_L  = HP_W'(MAX_HP);

  logic                 tick_s;
  logic [NUM_ENEMY-1:0] near_s;
  logic                 contact_s;
  logic                 contact_r;

  atk_state_t           state_r, state_n;
  logic [7:0]           wcnt_r, wcnt_n;
  logic [7:0]           rcnt_r, rcnt_n;
  logic [HP_W-1:0]      hp_r, hp_n;
  logic                 hit_n;

  frame_tick u_frame_tick (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (frame_clk),
    .tick      (tick_s)
  );

  // Each enemy is checked independently; overlapping contacts collapse into one.
  for (genvar i = 0; i < NUM_ENEMY; i++) begin : g_contact
    assign near_s[i] = Enemy_Alive[i]
                     && (abs_diff(Enemy_X[i], Player_X) <= RANGE_L)
                     && (abs_diff(Enemy_Y[i], Player_Y) <= RANGE_L);
  end

  assign contact_s = |near_s;

`ifdef ENEMY_REGEN_EN
  localparam logic [15:0] REGEN_L = 16'(REGEN_FRAMES);
  logic [15:0] regen_r, regen_n;
`endif

  // Next-state, counter and HP computation.
  always_comb begin
    state_n = state_r;
    wcnt_n  = wcnt_r;
    rcnt_n  = rcnt_r;
    hp_n    = hp_r;
    hit_n   = 1'b0;
`ifdef ENEMY_REGEN_EN
    regen_n = regen_r;
`endif
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          if (contact_r) begin
            state_n = WINDUP;
            wcnt_n  = 8'd1;
`ifdef ENEMY_REGEN_EN
            regen_n = 16'd0;
`endif
          end else begin
`ifdef ENEMY_REGEN_EN
            if (regen_r + 16'd1 == REGEN_L) begin
              regen_n = 16'd0;
              hp_n    = (hp_r >= MAX_HP_L) ? MAX_HP_L : hp_r + 8'd1;
            end else begin
              regen_n = regen_r + 16'd1;
            end
`else
            state_n = IDLE;
`endif
          end
        end else begin
          state_n = IDLE;
        end
      end
      WINDUP: begin
        if (tick_s) begin
          if (!contact_r) begin
            state_n = IDLE;
          end else if (wcnt_r == WINDUP_L) begin
            state_n = STRIKE;
          end else begin
            wcnt_n = wcnt_r + 8'd1;
          end
        end else begin
          state_n = WINDUP;
        end
      end
      STRIKE: begin
        // Single-cycle state: damage is applied exactly once per strike.
        state_n = RECOVER;
        rcnt_n  = 8'd0;
        hp_n    = (hp_r <= DAMAGE_L) ? 8'd0 : hp_r - DAMAGE_L;
        hit_n   = 1'b1;
      end
      RECOVER: begin
        if (tick_s) begin
          if (rcnt_r + 8'd1 == RECOVER_L) begin
            state_n = (hp_r == 8'd0) ? DEAD : IDLE;
            rcnt_n  = 8'd0;
          end else begin
            rcnt_n = rcnt_r + 8'd1;
          end
        end else begin
          state_n = RECOVER;
        end
      end
      DEAD: begin
        state_n = DEAD;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters, contact sample and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r            <= IDLE;
      wcnt_r             <= 8'd0;
      rcnt_r             <= 8'd0;
      hp_r               <= MAX_HP_L;
      contact_r          <= 1'b0;
      Hit_Pulse          <= 1'b0;
      Enemy_Attack_Ready <= 1'b1;
      Player_Dead        <= 1'b0;
    end else begin
      state_r            <= state_n;
      wcnt_r             <= wcnt_n;
      rcnt_r             <= rcnt_n;
      hp_r               <= hp_n;
      contact_r          <= contact_s;
      Hit_Pulse          <= hit_n;
      Enemy_Attack_Ready <= !((state_r == STRIKE) || (state_r == RECOVER));
      Player_Dead        <= (state_r == DEAD);
    end
  end

`ifdef ENEMY_REGEN_EN
  // Idle no-contact frame counter for regeneration.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regen_r <= 16'd0;
    end else begin
      regen_r <= regen_n;
    end
  end
`endif

  assign Player_HP = hp_r;

endmodule

// File: tb/tb_enemy_attack_ctrl.sv
// Directed self-checking bench for enemy_attack_ctrl (default parameters).
module tb_enemy_attack_ctrl;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            frame_clk;
  logic [8:0]      Player_X, Player_Y;
  logic [3:0][8:0] Enemy_X, Enemy_Y;
  logic [3:0]      Enemy_Alive;
  logic            Enemy_Attack_Ready;
  logic            Hit_Pulse;
  logic [7:0]      Player_HP;
  logic            Player_Dead;

  int checks = 0;
  int failures = 0;
  int hit_cnt = 0;
  int ready_low_cnt = 0;

  enemy_attack_ctrl dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .frame_clk          (frame_clk),
    .Player_X           (Player_X),
    .Player_Y           (Player_Y),
    .Enemy_X            (Enemy_X),
    .Enemy_Y            (Enemy_Y),
    .Enemy_Alive        (Enemy_Alive),
    .Enemy_Attack_Ready (Enemy_Attack_Ready),
    .Hit_Pulse          (Hit_Pulse),
    .Player_HP          (Player_HP),
    .Player_Dead        (Player_Dead)
  );

  always #5 Clk = ~Clk;

  // Event counters observed away from the active edge.
  always @(negedge Clk) begin
    if (Hit_Pulse === 1'b1) hit_cnt = hit_cnt + 1;
    if (Enemy_Attack_Ready === 1'b0) ready_low_cnt = ready_low_cnt + 1;
  end

  task automatic frame_tick_once();
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) frame_tick_once();
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic place(input int idx, input int x, input int y, input logic alive);
    Enemy_X[idx] = 9'(x);
    Enemy_Y[idx] = 9'(y);
    Enemy_Alive[idx] = alive;
  endtask

  task automatic clear_enemies();
    for (int i = 0; i < 4; i++) place(i, 400, 400, 1'b0);
  endtask

  task automatic test_reset();
    int h0;
    Player_X = 9'd100;
    Player_Y = 9'd100;
    clear_enemies();
    frame_clk = 1'b0;
    Reset = 1'b1;
    #1;
    checks++;
    if (Enemy_Attack_Ready !== 1'b1 || Player_HP !== 8'd100 || Hit_Pulse !== 1'b0 || Player_Dead !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: ready=%b hp=%0d hit=%b dead=%b required ready=1 hp=100 hit=0 dead=0",
               Enemy_Attack_Ready, Player_HP, Hit_Pulse, Player_Dead);
    end
    do_reset();
    h0 = hit_cnt;
    ticks(10);
    checks++;
    if (Enemy_Attack_Ready !== 1'b1 || Player_HP !== 8'd100 || hit_cnt != h0) begin
      failures++;
      $display("FAIL idle_no_enemies: ready=%b hp=%0d hits=%0d required ready=1 hp=100 hits=0",
               Enemy_Attack_Ready, Player_HP, hit_cnt - h0);
    end
  endtask

  task automatic strike_from(input int x, input int y, input string name);
    int h0;
    h0 = hit_cnt;
    place(0, x, y, 1'b1);
    for (int t = 1; t <= 3; t++) begin
      frame_tick_once();
      checks++;
      if (hit_cnt != h0 || Enemy_Attack_Ready !== 1'b1) begin
        failures++;
        $display("FAIL %s_windup_t%0d: hits=%0d ready=%b required hits=0 ready=1",
                 name, t, hit_cnt - h0, Enemy_Attack_Ready);
      end
    end
    frame_tick_once();
    checks++;
    if (hit_cnt != h0 + 1 || Player_HP !== 8'd90 || Enemy_Attack_Ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_strike: hits=%0d hp=%0d ready=%b required hits=1 hp=90 ready=0",
               name, hit_cnt - h0, Player_HP, Enemy_Attack_Ready);
    end
  endtask

  task automatic test_strike();
    do_reset();
    clear_enemies();
    strike_from(105, 105, "strike");
    ticks(7);
    checks++;
    if (Enemy_Attack_Ready !== 1'b0) begin
      failures++;
      $display("FAIL recover_hold: ready=%b required 0", Enemy_Attack_Ready);
    end
    frame_tick_once();
    checks++;
    if (Enemy_Attack_Ready !== 1'b1 || Player_HP !== 8'd90) begin
      failures++;
      $display("FAIL recover_done: ready=%b hp=%0d required ready=1 hp=90", Enemy_Attack_Ready, Player_HP);
    end
  endtask

  task automatic test_range_edge();
    do_reset();
    clear_enemies();
    strike_from(88, 112, "edge");
  endtask

  task automatic test_abort();
    int h0, r0;
    do_reset();
    clear_enemies();
    h0 = hit_cnt;
    r0 = ready_low_cnt;
    place(0, 105, 105, 1'b1);
    ticks(2);
    place(0, 113, 100, 1'b1);
    ticks(4);
    checks++;
    if (hit_cnt != h0 || Player_HP !== 8'd100 || ready_low_cnt != r0) begin
      failures++;
      $display("FAIL abort: hits=%0d hp=%0d ready_low=%0d required hits=0 hp=100 ready_low=0",
               hit_cnt - h0, Player_HP, ready_low_cnt - r0);
    end
  endtask

  task automatic test_death();
    int h0, exp_hp;
    do_reset();
    clear_enemies();
    place(0, 300, 300, 1'b1);
    place(1, 112, 95, 1'b1);
    place(2, 90, 110, 1'b1);
    place(3, 100, 100, 1'b0);
    h0 = hit_cnt;
    for (int k = 1; k <= 10; k++) begin
      ticks(4);
      exp_hp = 100 - 10 * k;
      checks++;
      if (hit_cnt != h0 + k || Player_HP !== 8'(exp_hp)) begin
        failures++;
        $display("FAIL death_strike%0d: hits=%0d hp=%0d required hits=%0d hp=%0d",
                 k, hit_cnt - h0, Player_HP, k, exp_hp);
      end
      if (k == 10) begin
        checks++;
        if (Player_Dead !== 1'b0) begin
          failures++;
          $display("FAIL dead_early: dead=%b required 0", Player_Dead);
        end
      end
      ticks(8);
    end
    checks++;
    if (Player_Dead !== 1'b1 || Player_HP !== 8'd0 || Enemy_Attack_Ready !== 1'b1) begin
      failures++;
      $display("FAIL dead_state: dead=%b hp=%0d ready=%b required dead=1 hp=0 ready=1",
               Player_Dead, Player_HP, Enemy_Attack_Ready);
    end
    ticks(24);
    checks++;
    if (hit_cnt != h0 + 10 || Player_HP !== 8'd0 || Player_Dead !== 1'b1) begin
      failures++;
      $display("FAIL dead_ignores: hits=%0d hp=%0d dead=%b required hits=10 hp=0 dead=1",
               hit_cnt - h0, Player_HP, Player_Dead);
    end
  endtask

  task automatic test_reset_mid_recover();
    int h0;
    do_reset();
    clear_enemies();
    strike_from(95, 104, "midrst");
    ticks(3);
    h0 = hit_cnt;
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if (Player_HP !== 8'd100 || Enemy_Attack_Ready !== 1'b1 || Player_Dead !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: hp=%0d ready=%b dead=%b required hp=100 ready=1 dead=0",
               Player_HP, Enemy_Attack_Ready, Player_Dead);
    end
    clear_enemies();
    @(negedge Clk);
    Reset = 1'b0;
    ticks(3);
    checks++;
    if (hit_cnt != h0 || Player_HP !== 8'd100) begin
      failures++;
      $display("FAIL post_reset: hits=%0d hp=%0d required hits=0 hp=100", hit_cnt - h0, Player_HP);
    end
  endtask

  task automatic test_regen();
    int exp_hp;
`ifdef ENEMY_REGEN_EN
    exp_hp = 92;
`else
    exp_hp = 90;
`endif
    do_reset();
    clear_enemies();
    strike_from(110, 90, "regen");
    ticks(8);
    clear_enemies();
    ticks(120);
    checks++;
    if (Player_HP !== 8'(exp_hp)) begin
      failures++;
      $display("FAIL regen: hp=%0d required %0d", Player_HP, exp_hp);
    end
  endtask

  initial begin
    test_reset();
    test_strike();
    test_range_edge();
    test_abort();
    test_death();
    test_reset_mid_recover();
    test_regen();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
